// File: rtl/piso_tx_arb.sv
// Two-requester round-robin front end for a parallel-in/serial-out shifter.
// It grants one word at a time, loads it, frames N shift cycles and then waits GAP idle cycles.
module piso_tx_arb #(
    parameter int N   = 16,
    parameter int GAP = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    output logic [N-1:0] piso_d,
    output logic         piso_load,
    output logic         frame_valid,
    output logic         frame_last,
    output logic         frame_src,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshake: a requester holds valid and data until it sees ready; ready is a
    // one-cycle accept strobe, raised only in IDLE and only for the granted side.

    localparam int CW = $clog2(N) + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           last_grant_q, last_grant_d;
    logic [N-1:0]   piso_d_q, piso_d_d;
    logic           frame_src_q, frame_src_d;

    logic           grant_any;
    logic           grant_sel;

    // Arbitration: with both pending, the side not served last wins.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (state_q == S_IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_sel = ~last_grant_q;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_sel = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    // State register; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            piso_d_q     <= '0;
            frame_src_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            piso_d_q     <= piso_d_d;
            frame_src_q  <= frame_src_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        piso_d_d     = piso_d_q;
        frame_src_d  = frame_src_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d      = S_LOAD;
                    piso_d_d     = grant_sel ? req1_data : req0_data;
                    frame_src_d  = grant_sel;
                    last_grant_d = grant_sel;
                end
            end
            S_LOAD: begin
                state_d   = S_SHIFT;
                bit_cnt_d = '0;
            end
            S_SHIFT: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked by rst so an aborted frame emits nothing in the reset cycle.
    always_comb begin
        req0_ready  = grant_any && !grant_sel;
        req1_ready  = grant_any && grant_sel;
        piso_load   = (state_q == S_LOAD) && !rst;
        frame_valid = (state_q == S_SHIFT) && !rst;
        frame_last  = (state_q == S_SHIFT) && (bit_cnt_q == CNT_LAST) && !rst;
        busy        = (state_q != S_IDLE) && !rst;
        piso_d      = piso_d_q;
        frame_src   = frame_src_q;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_piso_tx_arb.sv
// Bench for piso_tx_arb: directed scenarios plus randomized traffic against a
// timeline model that predicts outputs from the number of cycles since the last grant.
module tb_piso_tx_arb;
    localparam int N = 16;
    localparam int GAP = 2;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, v0, v1;
    logic [N-1:0] d0, d1;
    logic rdy0, rdy1, load, fv, flast, src, busy;
    logic [N-1:0] pd;
    logic [1:0] dbg;

    logic g_rst, g_v0;
    logic [N-1:0] g_d0;
    logic g_rdy0, g_rdy1, g_load, g_fv, g_flast, g_src, g_busy;
    logic [N-1:0] g_pd;
    logic [1:0] g_dbg;

    piso_tx_arb #(.N(N), .GAP(GAP)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1),
        .piso_d(pd), .piso_load(load), .frame_valid(fv), .frame_last(flast),
        .frame_src(src), .busy(busy), .dbg_state(dbg)
    );

    piso_tx_arb #(.N(N), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst(g_rst),
        .req0_valid(g_v0), .req0_data(g_d0), .req0_ready(g_rdy0),
        .req1_valid(1'b0), .req1_data('0), .req1_ready(g_rdy1),
        .piso_d(g_pd), .piso_load(g_load), .frame_valid(g_fv), .frame_last(g_flast),
        .frame_src(g_src), .busy(g_busy), .dbg_state(g_dbg)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: cycles elapsed since the last grant decide every strobe.
    int m_since = NEVER;
    logic m_last = 1'b1;
    logic [N-1:0] m_d = '0;
    logic m_src = 1'b0;
    logic e_rdy0, e_rdy1, e_load, e_fv, e_last, e_busy, e_src;
    logic [N-1:0] e_d;

    task automatic model_eval();
        logic in_frame;
        in_frame = (m_since >= 1) && (m_since <= N + GAP + 1);
        e_busy = !rst && in_frame;
        e_load = !rst && (m_since == 1);
        e_fv   = !rst && (m_since >= 2) && (m_since <= N + 1);
        e_last = !rst && (m_since == N + 1);
        e_rdy0 = 1'b0;
        e_rdy1 = 1'b0;
        if (!rst && !in_frame) begin
            if (v0 && v1) begin
                if (m_last) e_rdy0 = 1'b1;
                else e_rdy1 = 1'b1;
            end else if (v0) e_rdy0 = 1'b1;
            else if (v1) e_rdy1 = 1'b1;
        end
        e_d = m_d;
        e_src = m_src;
    endtask

    task automatic model_commit();
        if (rst) begin
            m_since = NEVER;
            m_last = 1'b1;
            m_d = '0;
            m_src = 1'b0;
        end else if (e_rdy0 || e_rdy1) begin
            m_since = 1;
            m_last = e_rdy1;
            m_d = e_rdy1 ? d1 : d0;
            m_src = e_rdy1;
        end else if (m_since < NEVER) begin
            m_since++;
        end
    endtask

    task automatic drive(input logic r, input logic a0, input logic [N-1:0] b0,
                         input logic a1, input logic [N-1:0] b1);
        rst = r; v0 = a0; d0 = b0; v1 = a1; d1 = b1;
        #1;
        model_eval();
    endtask

    task automatic adv();
        model_commit();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        adv();
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++;
        if ({rdy0, rdy1, load, fv, flast, src, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 0000000", {rdy0, rdy1, load, fv, flast, src, busy});
        end
        checks++;
        if (pd !== '0) begin failures++; $display("FAIL reset_piso_d: got %h expected 0000", pd); end
        adv();
    endtask

    task automatic test_single();
        int nfv;
        drive(1'b0, 1'b1, 16'h8001, 1'b0, '0);
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
            failures++; $display("FAIL single_ready: got %b%b expected 10", rdy0, rdy1);
        end
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b0, '0);
        checks++;
        if (rdy0 !== 1'b0) begin failures++; $display("FAIL single_ready_pulse: got %b expected 0", rdy0); end
        checks++;
        if (load !== 1'b1 || pd !== 16'h8001 || src !== 1'b0) begin
            failures++; $display("FAIL single_load: got load=%b d=%h src=%b expected 1 8001 0", load, pd, src);
        end
        adv();
        nfv = 0;
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            if (fv === 1'b1) nfv++;
            checks++;
            if (flast !== (i == N - 1)) begin
                failures++; $display("FAIL single_last: shift %0d got %b expected %b", i, flast, (i == N - 1));
            end
            adv();
        end
        checks++;
        if (nfv != N) begin failures++; $display("FAIL single_frame_len: got %0d expected %0d", nfv, N); end
        for (int i = 0; i < GAP; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            checks++;
            if (fv !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL single_gap: got fv=%b busy=%b expected 0 1", fv, busy);
            end
            adv();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
        adv();
    endtask

    task automatic test_contention();
        int gcyc[$];
        logic gsrc[$];
        int t0;
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 70; i++) begin
            drive(1'b0, 1'b1, 16'hA5A5, 1'b1, 16'h5A5A);
            if (rdy0 === 1'b1 || rdy1 === 1'b1) begin
                gcyc.push_back(cyc - t0);
                gsrc.push_back(rdy1);
            end
            if (load === 1'b1) begin
                checks++;
                if (pd !== (src ? 16'h5A5A : 16'hA5A5)) begin
                    failures++; $display("FAIL cont_data: got %h for src %b", pd, src);
                end
            end
            adv();
        end
        checks++;
        if (gcyc.size() < 3) begin
            failures++; $display("FAIL cont_count: got %0d expected >=3", gcyc.size());
        end else begin
            checks++;
            if ({gsrc[0], gsrc[1], gsrc[2]} !== 3'b010) begin
                failures++; $display("FAIL cont_order: got %b%b%b expected 010", gsrc[0], gsrc[1], gsrc[2]);
            end
            checks++;
            if (gcyc[1] - gcyc[0] != N + GAP + 2 || gcyc[2] - gcyc[1] != N + GAP + 2) begin
                failures++; $display("FAIL cont_spacing: got %0d,%0d expected %0d", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1], N + GAP + 2);
            end
        end
    endtask

    task automatic test_fairness();
        logic gsrc[$];
        logic want0;
        logic prev;
        int t0;
        do_reset();
        t0 = cyc;
        want0 = 1'b0;
        prev = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (cyc - t0 == 25) want0 = 1'b1;
            drive(1'b0, want0, 16'h00F0, 1'b1, 16'h0F00);
            if (rdy0 === 1'b1 || rdy1 === 1'b1) begin
                if (v0 && v1) begin
                    checks++;
                    if (rdy1 === prev) begin
                        failures++; $display("FAIL fair_rr: granted %b twice while both waited", rdy1);
                    end
                end
                prev = rdy1;
                gsrc.push_back(rdy1);
                if (rdy0 === 1'b1) want0 = 1'b0;
            end
            adv();
        end
        checks++;
        if (gsrc.size() < 3 || {gsrc[0], gsrc[1], gsrc[2]} !== 3'b110) begin
            failures++; $display("FAIL fair_order: got %0d grants, first %b expected 110",
                                 gsrc.size(), (gsrc.size() > 0) ? gsrc[0] : 1'bx);
        end
    endtask

    task automatic test_reset_mid();
        int nfv;
        do_reset();
        drive(1'b0, 1'b1, 16'h1111, 1'b0, '0);
        adv();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            adv();
        end
        drive(1'b1, 1'b1, 16'h3333, 1'b0, '0);
        checks++;
        if (fv !== 1'b0 || rdy0 !== 1'b0 || load !== 1'b0) begin
            failures++; $display("FAIL rmid_rst_cycle: got fv=%b rdy=%b load=%b expected 000", fv, rdy0, load);
        end
        adv();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++;
        if (busy !== 1'b0 || fv !== 1'b0 || load !== 1'b0) begin
            failures++; $display("FAIL rmid_after: got busy=%b fv=%b load=%b expected 000", busy, fv, load);
        end
        adv();
        drive(1'b0, 1'b1, 16'h2222, 1'b0, '0);
        checks++;
        if (rdy0 !== 1'b1) begin failures++; $display("FAIL rmid_regrant: got %b expected 1", rdy0); end
        adv();
        nfv = 0;
        for (int i = 0; i < N + GAP + 1; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            if (i == 0) begin
                checks++;
                if (load !== 1'b1 || pd !== 16'h2222) begin
                    failures++; $display("FAIL rmid_load: got load=%b d=%h expected 1 2222", load, pd);
                end
            end
            if (fv === 1'b1) nfv++;
            adv();
        end
        checks++;
        if (nfv != N) begin failures++; $display("FAIL rmid_frame_len: got %0d expected %0d", nfv, N); end
    endtask

    task automatic test_mutation();
        int bad;
        do_reset();
        drive(1'b0, 1'b1, 16'h1234, 1'b0, '0);
        adv();
        bad = 0;
        for (int i = 0; i < N + GAP + 1; i++) begin
            drive(1'b0, 1'b0, 16'hFFFF, 1'b0, '0);
            if (pd !== 16'h1234 || src !== 1'b0) bad++;
            adv();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL mutation: %0d cycles with piso_d != 1234 (last %h)", bad, pd); end
    endtask

    task automatic test_random();
        logic p0, p1, r;
        logic [N-1:0] rd0, rd1;
        do_reset();
        p0 = 1'b0; p1 = 1'b0; rd0 = '0; rd1 = '0;
        for (int i = 0; i < 900; i++) begin
            if (p0 && e_rdy0) p0 = 1'b0;
            if (p1 && e_rdy1) p1 = 1'b0;
            if (p0 && $urandom_range(0, 11) == 0) p0 = 1'b0;
            else if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1'b1; rd0 = N'($urandom); end
            if (p1 && $urandom_range(0, 11) == 0) p1 = 1'b0;
            else if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1'b1; rd1 = N'($urandom); end
            if (!p0) rd0 = N'($urandom);
            if (!p1) rd1 = N'($urandom);
            r = ($urandom_range(0, 79) == 0);
            drive(r, p0, rd0, p1, rd1);
            checks++;
            if ({rdy0, rdy1} !== {e_rdy0, e_rdy1}) begin
                failures++; $display("FAIL rand_ready: cyc %0d got %b%b expected %b%b", cyc, rdy0, rdy1, e_rdy0, e_rdy1);
            end
            checks++;
            if ({load, fv, flast, busy} !== {e_load, e_fv, e_last, e_busy}) begin
                failures++; $display("FAIL rand_strobes: cyc %0d got %b expected %b", cyc,
                                     {load, fv, flast, busy}, {e_load, e_fv, e_last, e_busy});
            end
            checks++;
            if (pd !== e_d || src !== e_src) begin
                failures++; $display("FAIL rand_latch: cyc %0d got %h/%b expected %h/%b", cyc, pd, src, e_d, e_src);
            end
            adv();
        end
    endtask

    task automatic test_gap0();
        int gcyc[$];
        logic [N-1:0] gdat[$];
        int overlap;
        int bad_d;
        g_rst = 1'b1; g_v0 = 1'b0; g_d0 = '0;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        adv();
        overlap = 0;
        bad_d = 0;
        for (int i = 0; i < 80; i++) begin
            g_rst = 1'b0;
            g_v0 = 1'b1;
            g_d0 = N'($urandom);
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            if (g_fv === 1'b1 && g_load === 1'b1) overlap++;
            if (g_load === 1'b1 && gdat.size() > 0 && g_pd !== gdat[$]) bad_d++;
            if (g_rdy0 === 1'b1) begin gcyc.push_back(i); gdat.push_back(g_d0); end
            adv();
        end
        g_v0 = 1'b0;
        checks++;
        if (overlap != 0) begin failures++; $display("FAIL gap0_overlap: got %0d expected 0", overlap); end
        checks++;
        if (bad_d != 0) begin failures++; $display("FAIL gap0_data: got %0d bad loads expected 0", bad_d); end
        checks++;
        if (gcyc.size() < 4) begin
            failures++; $display("FAIL gap0_count: got %0d expected >=4", gcyc.size());
        end else begin
            for (int k = 1; k < gcyc.size(); k++) begin
                checks++;
                if (gcyc[k] - gcyc[k - 1] != N + 2) begin
                    failures++; $display("FAIL gap0_spacing: got %0d expected %0d", gcyc[k] - gcyc[k - 1], N + 2);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        g_rst = 1'b1; g_v0 = 1'b0; g_d0 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_reset_mid();
        test_mutation();
        test_random();
        test_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/piso_tx_arb.md
PISO_TX_ARB -- requirements
Module: piso_tx_arb

Interface
REQ-001 Parameter N, default 16, word width of the downstream PISO shift register.
REQ-002 Parameter GAP, default 2, idle cycles inserted between frames (0 allowed).
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a word pending.
REQ-006 req0_data  input  N  requester 0 word.
REQ-007 req0_ready  output  1  one-cycle accept strobe to requester 0.
REQ-008 req1_valid  input  1  requester 1 has a word pending.
REQ-009 req1_data  input  N  requester 1 word.
REQ-010 req1_ready  output  1  one-cycle accept strobe to requester 1.
REQ-011 piso_d  output  N  parallel word to PISO d port.
REQ-012 piso_load  output  1  PISO load strobe.
REQ-013 frame_valid  output  1  PISO serial out carries a payload bit this cycle.
REQ-014 frame_last  output  1  final payload bit of current frame.
REQ-015 frame_src  output  1  index of requester owning current frame.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, LOAD, SHIFT, GAP; all registered on clk.
REQ-018 IDLE: if neither valid, stay; else grant one requester, pulse its ready for exactly that cycle, latch its data into piso_d, latch frame_src, go to LOAD.
REQ-019 Arbitration round-robin: both valid -> grant the requester not granted most recently; single valid -> grant it regardless of pointer.
REQ-020 Round-robin pointer updates only on a grant; after reset requester 0 has priority.
REQ-021 Ready is never asserted outside IDLE; at most one ready high per cycle.
REQ-022 Requester SHALL hold valid and data stable until its ready; valid falling before ready is legal and loses nothing (no grant).
REQ-023 LOAD: piso_load=1 for exactly one cycle with piso_d stable; next state SHIFT; bit counter cleared to 0.
REQ-024 SHIFT: frame_valid=1 for exactly N consecutive cycles starting the cycle after piso_load; counter increments each cycle.
REQ-025 frame_last=1 only in the SHIFT cycle where counter equals N-1.
REQ-026 After last SHIFT cycle: GAP>0 -> GAP state for exactly GAP cycles, then IDLE; GAP=0 -> IDLE directly.
REQ-027 Grant-to-grant minimum spacing is N+GAP+2 cycles (IDLE, LOAD, N SHIFT, GAP).
REQ-028 piso_d and frame_src hold latched values from grant until next grant.
REQ-029 Counter width ceil(log2(N))+1 bits; no wrap inside a frame.
REQ-030 Data changes on a requester input after its ready have no effect on the frame in progress.

Reset
REQ-031 rst high at a clock edge -> next cycle: state IDLE, counter 0, pointer favors requester 0.
REQ-032 Reset values: req0_ready=0, req1_ready=0, piso_d=0, piso_load=0, frame_valid=0, frame_last=0, frame_src=0, busy=0.
REQ-033 Reset in LOAD, SHIFT or GAP aborts the frame immediately; no ready, load or frame strobe in the reset cycle or after until a new grant.
REQ-034 Reset overrides a simultaneous valid; no grant in a cycle where rst=1.

Verification (N=16, GAP=2)
REQ-035 Single request: req0_valid=1, req0_data=16'h8001 in IDLE -> req0_ready pulse 1 cycle, piso_load next cycle with piso_d=16'h8001, frame_valid 16 cycles, frame_last on 16th, frame_src=0.
REQ-036 Contention: both valid from reset, data0=16'hA5A5, data1=16'h5A5A -> grants 0 then 1 then 0, each grant spaced exactly 20 cycles, frame_src alternates 0,1,0.
REQ-037 Fairness: req1 valid continuously, req0 valid only for third grant window -> grant order 1,1,0 if pointer allows, never two consecutive req1 grants while req0 waits at a grant cycle.
REQ-038 Reset mid-frame: rst asserted 5 cycles into SHIFT -> next cycle busy=0, frame_valid=0; following request loads fresh data with full 16-cycle frame.
REQ-039 GAP=0 build: back-to-back req0 -> grants every 18 cycles; no cycle with frame_valid=1 and piso_load=1 together.
REQ-040 Data mutation: req0_data changes to 16'hFFFF one cycle after ready -> piso_d retains original 16'h1234 throughout frame.
